counter_game_ctrl: RTL and testbench

//  Parametrised multimode counter game controller: WIDTH-bit up/down counter in 4 step modes.

---
 rtl/counter_game_pkg.sv | 21 ++
 rtl/game_tally.sv | 24 ++
 rtl/counter_game_ctrl.sv | 137 +++++++++++++
 tb/tb_counter_game_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_game_pkg.sv
// Shared types for the counter game controller: FSM states, step modes and who-ended-the-game codes.
package counter_game_pkg;

    typedef enum logic [1:0] {
        GS_PLAY   = 2'd0,
        GS_RELOAD = 2'd1,
        GS_OVER   = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        MODE_UP1 = 2'd0,
        MODE_UP2 = 2'd1,
        MODE_DN1 = 2'd2,
        MODE_DN2 = 2'd3
    } game_mode_e;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_LOSE = 2'b01;
    localparam logic [1:0] WHO_WIN  = 2'b10;

endpackage

// File: rtl/game_tally.sv
// Saturating tally counter with synchronous clear; clear wins over increment.
module game_tally #(
    parameter int TALLY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [TALLY_W-1:0] tally
);

    localparam logic [TALLY_W-1:0] T_ONE = 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally <= '0;
        end else if (clr) begin
            tally <= '0;
        end else if (inc && (tally != '1)) begin
            tally <= tally + T_ONE;
        end
    end

endmodule

// File: rtl/counter_game_ctrl.sv
// Multimode up/down counter game core with win/lose tallies and sticky game-over.
// Optional pause input is compiled in when COUNTER_GAME_PAUSE_EN is defined.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// GS_PLAY   | counter steps each cycle per control; a hit moves to RELOAD
// GS_RELOAD | one cycle: clear pulse, reload count, check tally limit
// GS_OVER   | everything frozen until init restarts the game
module counter_game_ctrl
    import counter_game_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int TALLY_W   = 4,
    parameter int WIN_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [WIDTH-1:0]   initial_val,
    input  logic [1:0]         control,
`ifdef COUNTER_GAME_PAUSE_EN
    input  logic               pause,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               winner,
    output logic               loser,
    output logic [TALLY_W-1:0] win_tally,
    output logic [TALLY_W-1:0] lose_tally,
    output logic               gameover,
    output logic [1:0]         who
);

    localparam logic [1:0] S_PLAY   = GS_PLAY;
    localparam logic [1:0] S_RELOAD = GS_RELOAD;
    localparam logic [1:0] S_OVER   = GS_OVER;

    localparam logic [WIDTH-1:0]   C_ONE = 1;
    localparam logic [WIDTH-1:0]   C_TWO = 2;
    localparam logic [TALLY_W-1:0] LIMIT = WIN_LIMIT[TALLY_W-1:0];

    logic [1:0]       state;
    logic [WIDTH-1:0] nxt;
    logic             pause_i;
    logic             stepping;
    logic             hit_win;
    logic             hit_lose;
    logic             tally_clr;

`ifdef COUNTER_GAME_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    always_comb begin
        nxt = count;
        case (control)
            MODE_UP1: nxt = count + C_ONE;
            MODE_UP2: nxt = count + C_TWO;
            MODE_DN1: nxt = count - C_ONE;
            MODE_DN2: nxt = count - C_TWO;
            default:  nxt = count;
        endcase
    end

    // Only a real step can score; loads and pauses never generate a hit.
    assign stepping  = (state == S_PLAY) && !init && !pause_i;
    assign hit_win   = stepping && (nxt == '1);
    assign hit_lose  = stepping && (nxt == '0);
    assign tally_clr = (state == S_OVER) && init;

    game_tally #(.TALLY_W(TALLY_W)) u_win_tally (
        .clk   (clk),
        .rst   (rst),
        .clr   (tally_clr),
        .inc   (hit_win),
        .tally (win_tally)
    );

    game_tally #(.TALLY_W(TALLY_W)) u_lose_tally (
        .clk   (clk),
        .rst   (rst),
        .clr   (tally_clr),
        .inc   (hit_lose),
        .tally (lose_tally)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_PLAY;
            count    <= '0;
            winner   <= 1'b0;
            loser    <= 1'b0;
            gameover <= 1'b0;
            who      <= WHO_NONE;
        end else begin
            winner <= hit_win;
            loser  <= hit_lose;
            case (state)
                S_PLAY: begin
                    if (init) begin
                        count <= initial_val;
                    end else if (!pause_i) begin
                        count <= nxt;
                        if (hit_win || hit_lose) begin
                            state <= S_RELOAD;
                        end
                    end
                end
                S_RELOAD: begin
                    count <= init ? initial_val : '0;
                    if (win_tally == LIMIT) begin
                        state    <= S_OVER;
                        gameover <= 1'b1;
                        who      <= WHO_WIN;
                    end else if (lose_tally == LIMIT) begin
                        state    <= S_OVER;
                        gameover <= 1'b1;
                        who      <= WHO_LOSE;
                    end else begin
                        state <= S_PLAY;
                    end
                end
                S_OVER: begin
                    if (init) begin
                        count    <= initial_val;
                        gameover <= 1'b0;
                        who      <= WHO_NONE;
                        state    <= S_PLAY;
                    end
                end
                default: state <= S_PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_game_ctrl.sv
// Scoreboard bench for counter_game_ctrl (WIDTH=4, TALLY_W=4, WIN_LIMIT=3) with directed and random play.
module tb_counter_game_ctrl;

    localparam int W    = 4;
    localparam int TW   = 4;
    localparam int LIM  = 3;
    localparam int MOD  = 16;
    localparam int TMAX = 15;

    localparam int PH_PLAY   = 0;
    localparam int PH_RELOAD = 1;
    localparam int PH_OVER   = 2;

    typedef struct packed {
        logic [W-1:0]  count;
        logic          winner;
        logic          loser;
        logic [TW-1:0] wt;
        logic [TW-1:0] lt;
        logic          go;
        logic [1:0]    who;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic [W-1:0]  initial_val;
    logic [1:0]    control;
    logic          pause_drv;
    logic [W-1:0]  count;
    logic          winner;
    logic          loser;
    logic [TW-1:0] win_tally;
    logic [TW-1:0] lose_tally;
    logic          gameover;
    logic [1:0]    who;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];
    exp_t e_mon;
    exp_t a_mon;

    int DELTA[4] = '{1, 2, -1, -2};
    int m_count, m_wt, m_lt, m_go, m_who, m_phase;

    always #5 clk = ~clk;

    counter_game_ctrl #(.WIDTH(W), .TALLY_W(TW), .WIN_LIMIT(LIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .initial_val (initial_val),
        .control     (control),
`ifdef COUNTER_GAME_PAUSE_EN
        .pause       (pause_drv),
`endif
        .count       (count),
        .winner      (winner),
        .loser       (loser),
        .win_tally   (win_tally),
        .lose_tally  (lose_tally),
        .gameover    (gameover),
        .who         (who)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wt = 0; m_lt = 0; m_go = 0; m_who = 0; m_phase = PH_PLAY;
    endtask

    // Apply one cycle of stimulus and push the outputs the game rules predict after the next edge.
    task automatic drive(input logic i_init, input logic [W-1:0] i_val, input logic [1:0] i_ctrl,
                         input logic i_pause);
        exp_t e;
        int   nv;
        bit   paused;
        bit   pw, pl;
        @(negedge clk);
        rst = 1'b1; init = i_init; initial_val = i_val; control = i_ctrl; pause_drv = i_pause;
`ifdef COUNTER_GAME_PAUSE_EN
        paused = i_pause;
`else
        paused = 1'b0;
`endif
        pw = 0; pl = 0;
        if (m_phase == PH_OVER) begin
            if (i_init) begin
                m_count = int'(i_val); m_wt = 0; m_lt = 0; m_go = 0; m_who = 0; m_phase = PH_PLAY;
            end
        end else if (m_phase == PH_RELOAD) begin
            m_count = i_init ? int'(i_val) : 0;
            if (m_wt == LIM) begin
                m_phase = PH_OVER; m_go = 1; m_who = 2;
            end else if (m_lt == LIM) begin
                m_phase = PH_OVER; m_go = 1; m_who = 1;
            end else begin
                m_phase = PH_PLAY;
            end
        end else begin
            if (i_init) begin
                m_count = int'(i_val);
            end else if (!paused) begin
                nv = (m_count + DELTA[i_ctrl] + MOD) % MOD;
                m_count = nv;
                if (nv == MOD - 1) begin
                    pw = 1; if (m_wt < TMAX) m_wt++; m_phase = PH_RELOAD;
                end else if (nv == 0) begin
                    pl = 1; if (m_lt < TMAX) m_lt++; m_phase = PH_RELOAD;
                end
            end
        end
        e.count  = W'(m_count);
        e.winner = pw;
        e.loser  = pl;
        e.wt     = TW'(m_wt);
        e.lt     = TW'(m_lt);
        e.go     = m_go[0];
        e.who    = 2'(m_who);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            a_mon = {count, winner, loser, win_tally, lose_tally, gameover, who};
            n_tests++;
            if (a_mon !== e_mon) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got cnt=%0d w=%0b l=%0b wt=%0d lt=%0d go=%0b who=%b expected cnt=%0d w=%0b l=%0b wt=%0d lt=%0d go=%0b who=%b",
                         $time, a_mon.count, a_mon.winner, a_mon.loser, a_mon.wt, a_mon.lt, a_mon.go, a_mon.who,
                         e_mon.count, e_mon.winner, e_mon.loser, e_mon.wt, e_mon.lt, e_mon.go, e_mon.who);
            end
        end
    end

    initial begin
        rst = 1'b0; init = 1'b0; initial_val = '0; control = 2'd0; pause_drv = 1'b0;
        model_reset();
        #23;
        check("reset_count", 32'(count), 0);
        check("reset_pulses", {30'd0, winner, loser}, 0);
        check("reset_tallies", {24'd0, win_tally, lose_tally}, 0);
        check("reset_go_who", {29'd0, gameover, who}, 0);

        // down-one from zero hits all-ones, then reload to zero
        drive(0, 0, 2, 0);
        drive(0, 0, 2, 0);
        // wrap 14+2 -> 0 scores a loss
        drive(1, 14, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        // two more wins reach the limit of 3
        repeat (4) drive(0, 0, 2, 0);
        repeat (10) drive(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0);
        drive(1, 5, 0, 0);
        // init held at all-ones never scores
        repeat (5) drive(1, 15, 2'($urandom_range(0, 3)), 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // async reset while in RELOAD
        drive(1, 1, 0, 0);
        drive(0, 0, 2, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_reload_count", 32'(count), 0);
        check("rst_reload_pulses", {30'd0, winner, loser}, 0);
        check("rst_reload_tallies", {24'd0, win_tally, lose_tally}, 0);
        check("rst_reload_go_who", {29'd0, gameover, who}, 0);
        model_reset();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
`ifdef COUNTER_GAME_PAUSE_EN
        drive(1, 7, 0, 0);
        repeat (4) drive(0, 0, 2'($urandom_range(0, 3)), 1);
        drive(0, 0, 0, 0);
`endif
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
